huff_bit_buffer: RTL and testbench
==================================

# huff_bit_buffer

Parametrised bitstream buffer for the Huffman encoder back end. Collects the serial code bits produced by the encoder, one bit per cycle, into an internal MSB-first buffer of configurable capacity. On end of stream it drains the buffer as WORD_W-bit words over a valid/ready handshake, then returns to accepting the next stream. It replaces the fixed 1024-bit store stage and adds overflow detection, backpressure, partial-word reporting and back-to-back stream support.

## Interface
- MAX_BITS, 1024, buffer capacity in bits; must be a multiple of WORD_W.
- WORD_W, 32, output word width in bits.
- CNT_W, $clog2(MAX_BITS+1), width of the bit counter (derived, not overridden).
- clk_i  in  1  clock; all logic on the rising edge.
- rst_i  in  1  synchronous, active-high reset.
- bit_valid_i  in  1  bit_i carries a code bit this cycle.
- bit_i  in  1  code bit.
- flush_i  in  1  end of stream; one-cycle pulse.
- in_ready_o  out  1  buffer is accepting bits (FILL state).
- out_valid_o  out  1  out_word_o is valid.
- rd_ready_i  in  1  downstream accepts the word.
- out_word_o  out  WORD_W  packed bits; first-received bit at MSB.
- out_nbits_o  out  $clog2(WORD_W+1)  number of valid bits in out_word_o.
- out_last_o  out  1  current word is the last word of the stream.
- total_bit_o  out  CNT_W  bits stored in the current stream.
- overflow_o  out  1  sticky; a bit was dropped because the buffer was full.
- done_o  out  1  one-cycle pulse after the last word is accepted.

## Operation
- States: FILL, DRAIN, DONE. Reset enters FILL.
- Reset values: in_ready_o=1, out_valid_o=0, out_word_o=0, out_nbits_o=0, out_last_o=0, total_bit_o=0, overflow_o=0, done_o=0. Buffer contents don't-care.
- FILL: when bit_valid_i is high and total_bit_o<MAX_BITS, store bit_i at position total_bit_o (position 0 = MSB of word 0) and increment total_bit_o. When total_bit_o==MAX_BITS and a bit arrives, drop it and set overflow_o.
- FILL with flush_i: a bit that arrives in the same cycle as flush_i is stored first. The block then enters DRAIN, with the read word index set to 0.
- DRAIN: present word k with out_valid_o=1. Bits beyond total_bit_o are zero-padded. out_nbits_o=min(WORD_W, total−k·WORD_W). out_last_o is high on word ceil(total/WORD_W)−1. in_ready_o=0. bit_valid_i and flush_i are ignored.
- DRAIN handshake: a word is accepted when out_valid_o && rd_ready_i. On acceptance of the last word, go to DONE.
- Zero-bit stream: flush in FILL with total_bit_o==0 goes directly to DONE. No word is output.
- DONE: done_o=1 for one cycle. Clear total_bit_o and overflow_o. Go to FILL.
- Reset asserted in any state, including mid-drain, aborts the stream and restores the reset values.

## Timing
- A bit accepted at edge t is reflected in total_bit_o after edge t.
- flush_i sampled at edge t: out_valid_o=1 with word 0 after edge t (one cycle latency).
- No bubble between words. After a handshake at edge t, word k+1 is valid after edge t.
- out_word_o, out_nbits_o and out_last_o are registered and held stable while out_valid_o=1 and rd_ready_i=0.
- Last handshake at edge t: done_o=1 after edge t; in_ready_o=1 after edge t+1.

## Configuration
- HUFF_BUF_SERIAL_EN defined: serial mode. Each handshake emits one bit in out_word_o[0]; the upper bits are 0 and out_nbits_o=1. The stream takes total_bit_o handshakes, and out_last_o is high on the final bit.
- HUFF_BUF_SERIAL_EN undefined: word mode, as described above.

## Test plan
- 40 bits, alternating 1,0 starting with 1, then flush, rd_ready_i held high → word0=0xAAAAAAAA with nbits=32 and last=0; word1=0xAA000000 with nbits=8 and last=1; done_o pulses one cycle after.
- Flush with no bits → no out_valid_o; done_o=1 on the next cycle; in_ready_o=1 the cycle after.
- MAX_BITS=64, 70 bits of 1 then flush → total_bit_o=64, overflow_o=1; two words of 0xFFFFFFFF; overflow_o=0 after done.
- 32 bits, then flush, with rd_ready_i low for 3 cycles → out_valid_o high and out_word_o stable for all 3 cycles; a single handshake on the 4th cycle; no bits accepted meanwhile.
- bit_valid_i=1 with bit_i=1 in the same cycle as flush_i, after 31 zeros → word0=0x00000001, nbits=32, last=1.
- rst_i during DRAIN of a 3-word stream → the following cycle shows out_valid_o=0, total_bit_o=0, in_ready_o=1; a new 8-bit stream then drains correctly.

Source files
------------

// File: rtl/huff_bit_buffer.sv
`default_nettype none
// ============================================================================
// Module      : huff_bit_buffer
// Description : Bitstream buffer for the Huffman encoder back end. Collects
//               serial code bits MSB-first into a MAX_BITS store, then on
//               end of stream drains them as WORD_W-bit words over a
//               valid/ready handshake and returns to accepting bits.
//               Optional macro HUFF_BUF_SERIAL_EN: drain one bit per
//               handshake in out_word_o[0] instead of whole words.
// Revision    : 1.0 - initial release
// ============================================================================
module huff_bit_buffer #(
  parameter int MAX_BITS = 1024,
  parameter int WORD_W   = 32,
  parameter int CNT_W    = $clog2(MAX_BITS + 1)
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         bit_valid_i,
  input  logic                         bit_i,
  input  logic                         flush_i,
  output logic                         in_ready_o,
  output logic                         out_valid_o,
  input  logic                         rd_ready_i,
  output logic [WORD_W-1:0]            out_word_o,
  output logic [$clog2(WORD_W+1)-1:0]  out_nbits_o,
  output logic                         out_last_o,
  output logic [CNT_W-1:0]             total_bit_o,
  output logic                         overflow_o,
  output logic                         done_o
);

  localparam int NB_W   = $clog2(WORD_W + 1);
  localparam int NWORDS = MAX_BITS / WORD_W;
  localparam int WIDX_W = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam logic [WORD_W-1:0] MSB_ONE = {1'b1, {(WORD_W-1){1'b0}}};

  typedef enum logic [1:0] {
    S_FILL  = 2'd0,
    S_DRAIN = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    total_q, total_d;
  logic                ovf_q, ovf_d;
  logic                done_q, done_d;
  logic                out_valid_q, out_valid_d;
  logic [WORD_W-1:0]   out_word_q, out_word_d;
  logic [NB_W-1:0]     out_nbits_q, out_nbits_d;
  logic                out_last_q, out_last_d;
  // bits still to be presented after the word currently on the output
  logic [CNT_W-1:0]    rem_q, rem_d;
  // index (word, or bit in serial mode) of the item currently on the output
  logic [CNT_W-1:0]    rd_idx_q, rd_idx_d;

  // Bit store; contents are only meaningful below total_q
  logic [WORD_W-1:0]   buf_mem [NWORDS];

  // Write path signals
  logic                wr_en;
  logic [WIDX_W-1:0]   wr_word_idx;
  logic [CNT_W-1:0]    wr_off;
  logic [WORD_W-1:0]   wr_mask;
  logic [WORD_W-1:0]   wr_word;

  // Load path signals
  logic                load_en;
  logic [CNT_W-1:0]    load_idx;
  logic [CNT_W-1:0]    load_rem;
  logic [WORD_W-1:0]   load_word;
  logic [NB_W-1:0]     load_nbits;
  logic [WIDX_W-1:0]   rd_widx;
`ifdef HUFF_BUF_SERIAL_EN
  logic [CNT_W-1:0]    rd_off;
  logic                rd_bit;
`endif

  // Word being written this cycle; the first bit of a word clears the rest so
  // positions beyond the stream end read back as zero padding
  always_comb begin
    wr_en       = (state_q == S_FILL) && bit_valid_i && (total_q < CNT_W'(MAX_BITS));
    wr_word_idx = WIDX_W'(total_q / CNT_W'(WORD_W));
    wr_off      = total_q % CNT_W'(WORD_W);
    wr_mask     = MSB_ONE >> wr_off;
    wr_word     = (wr_off == '0) ? '0 : buf_mem[wr_word_idx];
    if (bit_i) begin
      wr_word = wr_word | wr_mask;
    end else begin
      wr_word = wr_word & ~wr_mask;
    end
  end

  // Bit store write; no reset needed as stale data is never read unmasked
  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      buf_mem[wr_word_idx] <= wr_word;
    end
  end

  // Next-state logic for the FILL/DRAIN/DONE controller and output registers
  always_comb begin
    state_d     = state_q;
    total_d     = total_q;
    ovf_d       = ovf_q;
    done_d      = 1'b0;
    out_valid_d = out_valid_q;
    out_word_d  = out_word_q;
    out_nbits_d = out_nbits_q;
    out_last_d  = out_last_q;
    rem_d       = rem_q;
    rd_idx_d    = rd_idx_q;
    load_en     = 1'b0;
    load_idx    = '0;
    load_rem    = '0;
    load_word   = '0;
    load_nbits  = '0;
    rd_widx     = '0;
`ifdef HUFF_BUF_SERIAL_EN
    rd_off      = '0;
    rd_bit      = 1'b0;
`endif

    case (state_q)
      S_FILL: begin
        if (bit_valid_i) begin
          if (wr_en) begin
            total_d = total_q + CNT_W'(1);
          end else begin
            ovf_d = 1'b1;
          end
        end
        // a bit arriving with flush has already been counted in total_d
        if (flush_i) begin
          if (total_d == '0) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            state_d  = S_DRAIN;
            load_en  = 1'b1;
            load_idx = '0;
            load_rem = total_d;
          end
        end
      end

      S_DRAIN: begin
        if (out_valid_q && rd_ready_i) begin
          if (out_last_q) begin
            state_d     = S_DONE;
            done_d      = 1'b1;
            out_valid_d = 1'b0;
          end else begin
            load_en  = 1'b1;
            load_idx = rd_idx_q + CNT_W'(1);
            load_rem = rem_q;
          end
        end
      end

      S_DONE: begin
        total_d = '0;
        ovf_d   = 1'b0;
        state_d = S_FILL;
      end

      default: begin
        state_d = S_FILL;
      end
    endcase

    // Fetch the next item into the output registers; at flush time the bit
    // written in the same cycle is forwarded since the store is not yet updated
    if (load_en) begin
`ifdef HUFF_BUF_SERIAL_EN
      rd_widx = WIDX_W'(load_idx / CNT_W'(WORD_W));
      rd_off  = load_idx % CNT_W'(WORD_W);
      if (wr_en && (total_q == '0)) begin
        rd_bit = bit_i;
      end else begin
        rd_bit = |(buf_mem[rd_widx] & (MSB_ONE >> rd_off));
      end
      load_word  = {{(WORD_W-1){1'b0}}, rd_bit};
      load_nbits = NB_W'(1);
      out_last_d = (load_rem == CNT_W'(1));
      rem_d      = load_rem - CNT_W'(1);
`else
      rd_widx = WIDX_W'(load_idx);
      if (wr_en && (wr_word_idx == '0)) begin
        load_word = wr_word;
      end else begin
        load_word = buf_mem[rd_widx];
      end
      if (load_rem >= CNT_W'(WORD_W)) begin
        load_nbits = NB_W'(WORD_W);
      end else begin
        load_nbits = NB_W'(load_rem);
      end
      out_last_d = (load_rem <= CNT_W'(WORD_W));
      rem_d      = load_rem - CNT_W'(load_nbits);
`endif
      out_valid_d = 1'b1;
      out_word_d  = load_word;
      out_nbits_d = load_nbits;
      rd_idx_d    = load_idx;
    end
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_FILL;
      total_q     <= '0;
      ovf_q       <= 1'b0;
      done_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_word_q  <= '0;
      out_nbits_q <= '0;
      out_last_q  <= 1'b0;
      rem_q       <= '0;
      rd_idx_q    <= '0;
    end else begin
      state_q     <= state_d;
      total_q     <= total_d;
      ovf_q       <= ovf_d;
      done_q      <= done_d;
      out_valid_q <= out_valid_d;
      out_word_q  <= out_word_d;
      out_nbits_q <= out_nbits_d;
      out_last_q  <= out_last_d;
      rem_q       <= rem_d;
      rd_idx_q    <= rd_idx_d;
    end
  end

  assign in_ready_o  = (state_q == S_FILL);
  assign out_valid_o = out_valid_q;
  assign out_word_o  = out_word_q;
  assign out_nbits_o = out_nbits_q;
  assign out_last_o  = out_last_q;
  assign total_bit_o = total_q;
  assign overflow_o  = ovf_q;
  assign done_o      = done_q;

endmodule
`default_nettype wire

// File: tb/tb_huff_bit_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_huff_bit_buffer
// Description : Scoreboard bench for huff_bit_buffer (MAX_BITS=96, WORD_W=32).
//               Stimulus pushes expected words built from a bit-queue model;
//               a negedge monitor pops and compares on every handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_huff_bit_buffer;

  localparam int MAXB = 96;
  localparam int W    = 32;
  localparam int CW   = $clog2(MAXB + 1);
  localparam int NBW  = $clog2(W + 1);

  logic           clk = 1'b0;
  logic           rst_i = 1'b1;
  logic           bit_valid_i = 1'b0;
  logic           bit_i = 1'b0;
  logic           flush_i = 1'b0;
  logic           rd_ready_i = 1'b1;
  logic           in_ready_o;
  logic           out_valid_o;
  logic [W-1:0]   out_word_o;
  logic [NBW-1:0] out_nbits_o;
  logic           out_last_o;
  logic [CW-1:0]  total_bit_o;
  logic           overflow_o;
  logic           done_o;

  huff_bit_buffer #(.MAX_BITS(MAXB), .WORD_W(W)) dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .bit_valid_i (bit_valid_i),
    .bit_i       (bit_i),
    .flush_i     (flush_i),
    .in_ready_o  (in_ready_o),
    .out_valid_o (out_valid_o),
    .rd_ready_i  (rd_ready_i),
    .out_word_o  (out_word_o),
    .out_nbits_o (out_nbits_o),
    .out_last_o  (out_last_o),
    .total_bit_o (total_bit_o),
    .overflow_o  (overflow_o),
    .done_o      (done_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0]   w;
    logic [NBW-1:0] nb;
    logic           last;
  } exp_t;

  exp_t exp_q[$];
  bit   model_bits[$];
  bit   model_ovf;
  int   n_checks = 0;
  int   n_pass   = 0;
  int   rdy_mode = 0;  // 0: always ready, 1: random, 2: driven by the stimulus

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
  endtask

  task automatic fail_now(input string name, input int act, input int req);
    n_checks++;
    $display("FAIL %s: got %0d required %0d", name, act, req);
  endtask

  // Reference: split the accepted bit list into output items
  task automatic build_expected();
    int   n;
    exp_t e;
    n = model_bits.size();
`ifdef HUFF_BUF_SERIAL_EN
    for (int i = 0; i < n; i++) begin
      e.w    = '0;
      e.w[0] = model_bits[i];
      e.nb   = NBW'(1);
      e.last = (i == n - 1);
      exp_q.push_back(e);
    end
`else
    for (int k = 0; k * W < n; k++) begin
      e.w = '0;
      for (int j = 0; j < W; j++)
        if (k * W + j < n) e.w[W-1-j] = model_bits[k*W+j];
      e.nb   = NBW'((n - k * W) < W ? (n - k * W) : W);
      e.last = ((k + 1) * W >= n);
      exp_q.push_back(e);
    end
`endif
  endtask

  function automatic bit genbit(input int pat, input int i, input int n);
    case (pat)
      1:       return (i % 2 == 0);
      2:       return 1'b1;
      3:       return 1'b0;
      4:       return (i == n - 1);
      default: return 1'($urandom);
    endcase
  endfunction

  task automatic accept_bit(input bit b);
    if (model_bits.size() < MAXB) model_bits.push_back(b);
    else model_ovf = 1'b1;
  endtask

  task automatic send_bits(input int cnt, input int pat, input int n);
    model_bits.delete();
    model_ovf = 1'b0;
    for (int i = 0; i < cnt; i++) begin
      bit_valid_i = 1'b1;
      bit_i       = genbit(pat, i, n);
      accept_bit(bit_i);
      @(posedge clk); #1;
    end
    bit_valid_i = 1'b0;
  endtask

  task automatic do_flush(input bit fbit, input bit b);
    flush_i = 1'b1;
    if (fbit) begin
      bit_valid_i = 1'b1;
      bit_i       = b;
      accept_bit(b);
    end
    build_expected();
    @(posedge clk); #1;
    flush_i     = 1'b0;
    bit_valid_i = 1'b0;
  endtask

  // Full stream: bits, flush, drain under the chosen ready mode, done checks
  task automatic run_stream(input int n, input int pat, input bit fbit, input int rmode);
    int  nexp;
    bit  seen;
    rdy_mode = rmode;
    if (rmode == 2) rd_ready_i = 1'b0;
    send_bits(fbit ? n - 1 : n, pat, n);
    do_flush(fbit, fbit ? genbit(pat, n - 1, n) : 1'b0);
    nexp = model_bits.size();
    chk("total_after_flush", total_bit_o, nexp);
    chk("overflow_after_flush", overflow_o, model_ovf);
    if (nexp == 0) begin
      chk("zero_done", done_o, 1);
      chk("zero_valid", out_valid_o, 0);
      @(posedge clk); #1;
      chk("zero_in_ready", in_ready_o, 1);
      chk("zero_done_clear", done_o, 0);
      return;
    end
    chk("first_valid", out_valid_o, 1);
    chk("drain_in_ready", in_ready_o, 0);
    seen = 1'b0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (rmode == 2 && cyc == 3) begin
        chk("stall_total_held", total_bit_o, nexp);
        rd_ready_i = 1'b1;
      end
      bit_valid_i = 1'($urandom);
      bit_i       = 1'($urandom);
      flush_i     = 1'($urandom);
      @(posedge clk); #1;
      if (done_o) begin
        seen = 1'b1;
        break;
      end
    end
    bit_valid_i = 1'b0;
    flush_i     = 1'b0;
    if (!seen) begin
      fail_now("done_timeout", 0, 1);
      return;
    end
    chk("all_words_consumed", exp_q.size(), 0);
    chk("done_valid_low", out_valid_o, 0);
    chk("done_in_ready_low", in_ready_o, 0);
    @(posedge clk); #1;
    chk("post_in_ready", in_ready_o, 1);
    chk("post_total", total_bit_o, 0);
    chk("post_overflow", overflow_o, 0);
    chk("post_done", done_o, 0);
  endtask

  // Ready driver
  initial begin
    forever begin
      @(posedge clk); #1;
      if (rdy_mode == 0) rd_ready_i = 1'b1;
      else if (rdy_mode == 1) rd_ready_i = 1'($urandom);
    end
  end

  // Monitor: compare each accepted word, and check hold while stalled
  initial begin
    bit             prev_stall = 1'b0;
    logic [W-1:0]   h_w;
    logic [NBW-1:0] h_nb;
    logic           h_last;
    exp_t           e;
    forever begin
      @(negedge clk);
      if (rst_i) begin
        prev_stall = 1'b0;
      end else if (out_valid_o) begin
        if (prev_stall) begin
          chk("hold_word", out_word_o, h_w);
          chk("hold_nbits", out_nbits_o, h_nb);
          chk("hold_last", out_last_o, h_last);
        end
        if (rd_ready_i) begin
          if (exp_q.size() == 0) begin
            fail_now("unexpected_word", 1, 0);
          end else begin
            e = exp_q.pop_front();
            chk("word", out_word_o, e.w);
            chk("nbits", out_nbits_o, e.nb);
            chk("last", out_last_o, e.last);
          end
        end
        prev_stall = !rd_ready_i;
        h_w        = out_word_o;
        h_nb       = out_nbits_o;
        h_last     = out_last_o;
      end else begin
        prev_stall = 1'b0;
      end
    end
  end

  // Main stimulus
  initial begin
    int n;
    rst_i = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_i = 1'b0;
    chk("rst_in_ready", in_ready_o, 1);
    chk("rst_out_valid", out_valid_o, 0);
    chk("rst_out_word", out_word_o, 0);
    chk("rst_out_nbits", out_nbits_o, 0);
    chk("rst_out_last", out_last_o, 0);
    chk("rst_total", total_bit_o, 0);
    chk("rst_overflow", overflow_o, 0);
    chk("rst_done", done_o, 0);

    run_stream(40, 1, 1'b0, 0);   // alternating 1,0: 0xAAAAAAAA then 0xAA000000
    run_stream(0, 0, 1'b0, 0);    // empty stream
    run_stream(100, 2, 1'b0, 0);  // overflow past capacity
    run_stream(32, 0, 1'b0, 2);   // three stall cycles before the handshake
    run_stream(32, 4, 1'b1, 0);   // 31 zeros then a 1 together with flush

    // Reset in the middle of draining a 3-word stream
    rdy_mode = 0;
    send_bits(80, 0, 80);
    do_flush(1'b0, 1'b0);
    chk("abort_first_valid", out_valid_o, 1);
    @(posedge clk); #1;
    rst_i = 1'b1;
    @(posedge clk); #1;
    rst_i = 1'b0;
    chk("abort_valid", out_valid_o, 0);
    chk("abort_total", total_bit_o, 0);
    chk("abort_in_ready", in_ready_o, 1);
    chk("abort_done", done_o, 0);
    exp_q.delete();
    run_stream(8, 0, 1'b0, 0);

    // Randomized streams
    for (int s = 0; s < 20; s++) begin
      n = $urandom_range(0, 110);
      run_stream(n, 0, (n > 0) ? 1'($urandom) : 1'b0, 1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
